// File: rtl/adder_self_test.sv
// -----------------------------------------------------------------------------
// adder_self_test
//
// Exhaustive built-in self test for an external WIDTH-bit adder. A start pulse
// sweeps every {x, y, carry_in} combination. Each vector is driven, the block
// waits LATENCY cycles, and then checks {carry_out, z} against x + y + carry_in.
// The mismatch count and the first failing vector are reported in DONE.
//
// Parameters
//   WIDTH    operand width of the adder under test (1..9)
//   LATENCY  cycles from operand drive to valid z/carry_out (1..15)
//
// Ports
//   clock        single clock, rising edge
//   reset        synchronous, active-high
//   start        begins a sweep when sampled high in IDLE or DONE
//   x, y         operands driven to the adder
//   carry_in     carry input driven to the adder
//   z            adder sum returned
//   carry_out    adder carry returned
//   busy         high in DRIVE, WAIT and CHECK
//   done         high in DONE
//   pass         high in DONE when no mismatch was seen
//   error_count  mismatching vectors, saturating at 16'hFFFF
//   fail_vec     {x, y, carry_in} of the first mismatch, zero if none
//
// Optional feature
//   ADDER_SELF_TEST_STOP_ON_FAIL_EN : the first mismatch ends the sweep, and
//   x/y/carry_in keep the failing vector.
// -----------------------------------------------------------------------------
module adder_self_test #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   x,
  output logic [WIDTH-1:0]   y,
  output logic               carry_in,
  input  logic [WIDTH-1:0]   z,
  input  logic               carry_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        error_count,
  output logic [2*WIDTH:0]   fail_vec
);

  localparam int unsigned VW        = 2 * WIDTH + 1;
  localparam logic [3:0]  WAIT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state;
  logic [VW-1:0] vec;        // vector index; its bits are the driven operands
  logic [3:0]    wait_cnt;

  logic [WIDTH:0] expected;
  logic           mismatch;
  logic [15:0]    err_next;
  logic           last_vec;

  // The index register is the operand register: carry_in is the LSB, so it
  // toggles fastest, and x is the MSB field, so it toggles slowest.
  assign {x, y, carry_in} = vec;

  always_comb begin
    expected = {1'b0, x} + {1'b0, y} + (WIDTH + 1)'(carry_in);
    mismatch = ({carry_out, z} != expected);
    err_next = error_count;
    if (mismatch && (error_count != 16'hFFFF)) begin
      err_next = error_count + 16'd1;
    end
    last_vec = &vec;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      vec         <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      error_count <= '0;
      fail_vec    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_DRIVE;
            vec         <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            error_count <= '0;
            fail_vec    <= '0;
          end
        end
        S_DRIVE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_CHECK: begin
          error_count <= err_next;
          if (mismatch && (error_count == 16'd0)) begin
            fail_vec <= vec;
          end
`ifdef ADDER_SELF_TEST_STOP_ON_FAIL_EN
          if (mismatch || last_vec) begin
`else
          if (last_vec) begin
`endif
            // vec is left untouched so the operands keep the last vector.
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0);
          end else begin
            vec   <= vec + VW'(1);
            state <= S_DRIVE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_self_test.sv
// -----------------------------------------------------------------------------
// tb_adder_self_test
//
// Two instances share one clock:
//   u_narrow : WIDTH=2, LATENCY=2, behavioural 2-stage adder with an optional
//              z[0] stuck-at-0 fault.
//   u_wide   : WIDTH=WIDE_W, LATENCY=1, behavioural 1-stage correct adder.
// Expected sweep results are queued when start is driven and popped when the
// DUT raises done.
// -----------------------------------------------------------------------------
module tb_adder_self_test;

  localparam int unsigned WIDE_W   = 6;
  localparam int unsigned WIDE_CYC = (1 << (2 * WIDE_W + 1)) * 3;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [31:0] fv;
    int unsigned cycles;
  } result_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  result_t sb_n[$];
  result_t sb_w[$];

  // narrow instance signals
  logic       reset_narrow = 1'b1;
  logic       start_n      = 1'b0;
  logic       fault_n      = 1'b0;
  logic [1:0] x_n, y_n, z_n;
  logic       cin_n, cout_n, busy_n, done_n, pass_n;
  logic [15:0] err_n;
  logic [4:0]  fv_n;

  // wide instance signals
  logic              reset_wide = 1'b1;
  logic              start_w    = 1'b0;
  logic [WIDE_W-1:0] x_w, y_w, z_w;
  logic              cin_w, cout_w, busy_w, done_w, pass_w;
  logic [15:0]       err_w;
  logic [2*WIDE_W:0] fv_w;

  adder_self_test #(.WIDTH(2), .LATENCY(2)) u_narrow (
    .clock(clk), .reset(reset_narrow), .start(start_n),
    .x(x_n), .y(y_n), .carry_in(cin_n), .z(z_n), .carry_out(cout_n),
    .busy(busy_n), .done(done_n), .pass(pass_n),
    .error_count(err_n), .fail_vec(fv_n)
  );

  adder_self_test #(.WIDTH(WIDE_W), .LATENCY(1)) u_wide (
    .clock(clk), .reset(reset_wide), .start(start_w),
    .x(x_w), .y(y_w), .carry_in(cin_w), .z(z_w), .carry_out(cout_w),
    .busy(busy_w), .done(done_w), .pass(pass_w),
    .error_count(err_w), .fail_vec(fv_w)
  );

  // Adder models.
  logic [2:0] pipe_n [2];
  always @(posedge clk) begin
    pipe_n[0] <= ({1'b0, x_n} + {1'b0, y_n} + {2'b00, cin_n}) & (fault_n ? 3'b110 : 3'b111);
    pipe_n[1] <= pipe_n[0];
  end
  assign z_n    = pipe_n[1][1:0];
  assign cout_n = pipe_n[1][2];

  logic [WIDE_W:0] pipe_w;
  always @(posedge clk) begin
    pipe_w <= {1'b0, x_w} + {1'b0, y_w} + (WIDE_W + 1)'(cin_w);
  end
  assign z_w    = pipe_w[WIDE_W-1:0];
  assign cout_w = pipe_w[WIDE_W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outcome of a full narrow sweep against the stuck-at model.
  function automatic result_t fault_result();
    result_t r;
    int unsigned odd = 0;
    int unsigned first = 0;
    bit found = 0;
    for (int unsigned v = 0; v < 32; v++) begin
      if ((((v >> 3) & 3) + ((v >> 1) & 3) + (v & 1)) % 2 == 1) begin
        odd++;
        if (!found) begin first = v; found = 1; end
      end
    end
    r.pass = (odd == 0);
`ifdef ADDER_SELF_TEST_STOP_ON_FAIL_EN
    r.err    = 16'd1;
    r.cycles = (first + 1) * 4;
`else
    r.err    = odd[15:0];
    r.cycles = 32 * 4;
`endif
    r.fv = first;
    return r;
  endfunction

  task automatic narrow_sweep(input string tag, input result_t exp, input bit keep_start);
    int unsigned busy_cycles = 0;
    bit seen = 0;
    result_t e;
    @(negedge clk);
    start_n = 1'b1;
    sb_n.push_back(exp);
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (!keep_start) start_n = 1'b0;
      if (done_n) seen = 1;
      else if (busy_n) busy_cycles++;
    end
    if (!seen) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      void'(sb_n.pop_front());
    end else begin
      e = sb_n.pop_front();
      check({tag, " pass"},   pass_n, e.pass);
      check({tag, " err"},    err_n,  e.err);
      check({tag, " fv"},     fv_n,   e.fv);
      check({tag, " cycles"}, busy_cycles, e.cycles);
      check({tag, " busy@done"}, busy_n, 1'b0);
    end
  endtask

  result_t     fr;
  result_t     we;
  int unsigned wbusy;
  bit          wseen;
  int unsigned late_done, late_busy;

  initial begin
    fork
      begin : narrow_seq
        // Reset state and idle hold.
        repeat (3) @(negedge clk);
        check("rst busy", busy_n, 1'b0);
        check("rst done", done_n, 1'b0);
        check("rst pass", pass_n, 1'b0);
        check("rst err",  err_n, 16'd0);
        check("rst fv",   fv_n, 5'd0);
        check("rst vec",  {x_n, y_n, cin_n}, 5'd0);
        reset_narrow = 1'b0;
        repeat (5) @(negedge clk);
        check("idle busy", busy_n, 1'b0);
        check("idle done", done_n, 1'b0);

        // Correct adder.
        narrow_sweep("good", '{pass: 1'b1, err: 16'd0, fv: 32'd0, cycles: 128}, 1'b0);
        check("good vec", {x_n, y_n, cin_n}, 5'b11111);
        repeat (3) @(negedge clk);
        check("good hold done", done_n, 1'b1);
        check("good hold pass", pass_n, 1'b1);

        // z[0] stuck at 0, started from DONE.
        fault_n = 1'b1;
        fr = fault_result();
        narrow_sweep("stuck", fr, 1'b0);
`ifdef ADDER_SELF_TEST_STOP_ON_FAIL_EN
        check("stuck vec", {x_n, y_n, cin_n}, fr.fv);
`else
        check("stuck vec", {x_n, y_n, cin_n}, 5'b11111);
`endif

        // Reset in the middle of a sweep.
        @(negedge clk);
        start_n = 1'b1;
        @(negedge clk);
        start_n = 1'b0;
        repeat (49) @(negedge clk);
        reset_narrow = 1'b1;
        @(negedge clk);
        reset_narrow = 1'b0;
        check("midrst busy", busy_n, 1'b0);
        check("midrst done", done_n, 1'b0);
        check("midrst pass", pass_n, 1'b0);
        check("midrst err",  err_n, 16'd0);
        check("midrst fv",   fv_n, 5'd0);
        check("midrst vec",  {x_n, y_n, cin_n}, 5'd0);
        late_done = 0;
        late_busy = 0;
        repeat (200) begin
          @(negedge clk);
          if (done_n) late_done++;
          if (busy_n) late_busy++;
        end
        check("midrst no done", late_done, 0);
        check("midrst no busy", late_busy, 0);

        // start held high: one sweep, then an immediate restart from DONE.
        narrow_sweep("held", fr, 1'b1);
        @(negedge clk);
        check("restart busy", busy_n, 1'b1);
        check("restart done", done_n, 1'b0);
        check("restart pass", pass_n, 1'b0);
        check("restart err",  err_n, 16'd0);
        start_n = 1'b0;
        reset_narrow = 1'b1;
        @(negedge clk);
        reset_narrow = 1'b0;
      end
      begin : wide_seq
        repeat (3) @(negedge clk);
        reset_wide = 1'b0;
        @(negedge clk);
        start_w = 1'b1;
        sb_w.push_back('{pass: 1'b1, err: 16'd0, fv: 32'd0, cycles: WIDE_CYC});
        wbusy = 0;
        wseen = 0;
        for (int i = 0; i < WIDE_CYC + 100 && !wseen; i++) begin
          @(negedge clk);
          start_w = 1'b0;
          if (done_w) wseen = 1;
          else if (busy_w) wbusy++;
        end
        if (!wseen) begin
          check("wide timeout", 32'd0, 32'd1);
        end else begin
          we = sb_w.pop_front();
          check("wide pass",   pass_w, we.pass);
          check("wide err",    err_w, we.err);
          check("wide fv",     fv_w, we.fv);
          check("wide cycles", wbusy, we.cycles);
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
